// File: rtl/sccomp_run_ctrl_pkg.sv
// Shared types for the sccomp run controller: state encoding, command bundle, defaults.
// Latency: none (types, constants and one pure function only).
// Backpressure: not applicable.
package sccomp_ctrl_pkg;

  localparam int ST_W         = 2;
  localparam int DEF_NREGS    = 32;
  localparam int DEF_SEL_W    = 5;
  localparam int DEF_IDLE_SEL = 7;

  typedef enum logic [ST_W-1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_SCAN = 2'b11
  } state_e;

  typedef struct packed {
    logic halt;
    logic step;
    logic run;
    logic scan;
  } cmd_t;

  // Where HALT goes for a given set of same-cycle commands (halt > step > run > scan).
  function automatic state_e halt_next(input cmd_t c);
    if (c.halt) return ST_HALT;
    if (c.step) return ST_STEP;
    if (c.run)  return ST_RUN;
    if (c.scan) return ST_SCAN;
    return ST_HALT;
  endfunction

endpackage

// File: rtl/sccomp_run_ctrl_if.sv
// Control/debug bundle between the board side, sccomp and the run controller.
// Latency: wires only.
// Backpressure: scan_valid/scan_ready handshake; optional breakpoint signals under SCCOMP_RUN_CTRL_BREAKPOINT_EN.
interface sccomp_run_ctrl_if #(
  parameter int SEL_W = 5
);
  logic             cmd_run;
  logic             cmd_halt;
  logic             cmd_step;
  logic             cmd_scan;
  logic [31:0]      pc_in;
  logic             cpu_ce;
  logic [SEL_W-1:0] reg_sel;
  logic [31:0]      reg_data;
  logic             scan_valid;
  logic             scan_ready;
  logic [SEL_W-1:0] scan_idx;
  logic [31:0]      scan_data;
  logic [1:0]       state;
  logic [31:0]      retired;
`ifdef SCCOMP_RUN_CTRL_BREAKPOINT_EN
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic             bp_hit;

  modport master (
    input  cmd_run, cmd_halt, cmd_step, cmd_scan, pc_in, reg_data, scan_ready, bp_en, bp_addr,
    output cpu_ce, reg_sel, scan_valid, scan_idx, scan_data, state, retired, bp_hit
  );
  modport slave (
    output cmd_run, cmd_halt, cmd_step, cmd_scan, pc_in, reg_data, scan_ready, bp_en, bp_addr,
    input  cpu_ce, reg_sel, scan_valid, scan_idx, scan_data, state, retired, bp_hit
  );
`else
  modport master (
    input  cmd_run, cmd_halt, cmd_step, cmd_scan, pc_in, reg_data, scan_ready,
    output cpu_ce, reg_sel, scan_valid, scan_idx, scan_data, state, retired
  );
  modport slave (
    output cmd_run, cmd_halt, cmd_step, cmd_scan, pc_in, reg_data, scan_ready,
    input  cpu_ce, reg_sel, scan_valid, scan_idx, scan_data, state, retired
  );
`endif
endinterface

// File: rtl/sccomp_run_ctrl_scanner.sv
// sccomp_reg_scanner: walks register indices 0..NREGS-1, capturing each into a held beat.
// Latency: capture edge sets valid, so a beat appears 1 cycle after its capture cycle; one beat per 2 cycles.
// Backpressure: beat (valid/idx/data) held stable until ready; abort drops the beat and rewinds to index 0.
module sccomp_reg_scanner
  import sccomp_ctrl_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_active,
  input  logic             i_abort,
  input  logic [31:0]      i_reg_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [SEL_W-1:0] o_idx,
  output logic [31:0]      o_data,
  output logic             o_done
);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NREGS - 1);

  logic             r_valid;
  logic [SEL_W-1:0] r_idx;
  logic [31:0]      r_data;
  logic             w_hs;
  logic             w_last;

  assign w_hs   = r_valid && i_ready;
  assign w_last = (r_idx == LAST_IDX);
  assign o_done = i_active && w_hs && w_last;

  // Alternate capture and present; abort wins over any handshake in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
    end else if (i_abort) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else if (i_active) begin
      if (!r_valid) begin
        r_valid <= 1'b1;
        r_data  <= i_reg_data;
      end else if (i_ready) begin
        r_valid <= 1'b0;
        r_idx   <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_idx   = r_idx;
  assign o_data  = r_data;

endmodule

// File: rtl/sccomp_run_ctrl.sv
// sccomp_run_ctrl: run/halt/single-step sequencer for sccomp plus register-dump scanner front end.
// Latency: cpu_ce combinational from state; commands act on the next edge; scan beat 1 cycle after capture.
// Backpressure: scan beats held until scan_ready. Macro SCCOMP_RUN_CTRL_BREAKPOINT_EN adds PC breakpoint.
module sccomp_run_ctrl
  import sccomp_ctrl_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int IDLE_SEL = DEF_IDLE_SEL
) (
  input  logic              clk,
  input  logic              rstn,
  sccomp_run_ctrl_if.master bus
);
  state_e           r_state;
  state_e           w_state_nxt;
  cmd_t             w_cmd;
  logic             w_ce;
  logic             w_bp_gate;
  logic             w_scan_active;
  logic             w_scan_abort;
  logic             w_scan_done;
  logic [SEL_W-1:0] w_scan_idx;
  logic [31:0]      r_retired;

  assign w_cmd = '{halt: bus.cmd_halt, step: bus.cmd_step, run: bus.cmd_run, scan: bus.cmd_scan};

`ifdef SCCOMP_RUN_CTRL_BREAKPOINT_EN
  logic r_run_first;

  // The first RUN cycle after leaving HALT ignores a match so resuming at the breakpoint PC makes progress.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) r_run_first <= 1'b0;
    else      r_run_first <= (r_state != ST_RUN) && (w_state_nxt == ST_RUN);
  end

  assign w_bp_gate  = bus.bp_en && (bus.pc_in == bus.bp_addr) && !r_run_first;
  assign bus.bp_hit = (r_state == ST_RUN) && w_bp_gate;
`else
  assign w_bp_gate = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) r_state <= ST_HALT;
    else      r_state <= w_state_nxt;
  end

  // Next state, clock-enable and scan abort; unlisted commands for a state fall through ignored.
  always_comb begin
    w_state_nxt  = r_state;
    w_ce         = 1'b0;
    w_scan_abort = 1'b0;
    unique case (r_state)
      ST_HALT: w_state_nxt = halt_next(w_cmd);
      ST_RUN: begin
        // A breakpoint match blocks the instruction at that PC from retiring.
        w_ce = !w_bp_gate;
        if (w_cmd.halt || w_bp_gate) w_state_nxt = ST_HALT;
      end
      ST_STEP: begin
        w_ce        = 1'b1;
        w_state_nxt = ST_HALT;
      end
      ST_SCAN: begin
        if (w_cmd.halt) begin
          w_scan_abort = 1'b1;
          w_state_nxt  = ST_HALT;
        end else if (w_scan_done) begin
          w_state_nxt = ST_HALT;
        end
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  // Retired-instruction counter; wraps naturally, cleared only by reset.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)      r_retired <= '0;
    else if (w_ce) r_retired <= r_retired + 32'd1;
  end

  assign w_scan_active = (r_state == ST_SCAN);

  sccomp_reg_scanner #(
    .NREGS (NREGS),
    .SEL_W (SEL_W)
  ) u_scanner (
    .clk        (clk),
    .rst        (rstn),
    .i_active   (w_scan_active),
    .i_abort    (w_scan_abort),
    .i_reg_data (bus.reg_data),
    .i_ready    (bus.scan_ready),
    .o_valid    (bus.scan_valid),
    .o_idx      (w_scan_idx),
    .o_data     (bus.scan_data),
    .o_done     (w_scan_done)
  );

  assign bus.cpu_ce   = w_ce;
  assign bus.reg_sel  = w_scan_active ? w_scan_idx : SEL_W'(IDLE_SEL);
  assign bus.scan_idx = w_scan_idx;
  assign bus.state    = r_state;
  assign bus.retired  = r_retired;

endmodule

// File: tb/tb_sccomp_run_ctrl.sv
// Bench for sccomp_run_ctrl: random command sequences against an operation-level model,
// scan beats checked by a scoreboard monitor, register file and PC modelled here.
// Breakpoint checks are built only when SCCOMP_RUN_CTRL_BREAKPOINT_EN is defined.
module tb_sccomp_run_ctrl;
  import sccomp_ctrl_pkg::*;

  localparam int NREGS    = 32;
  localparam int SEL_W    = 5;
  localparam int IDLE_SEL = 7;

  typedef struct packed {
    logic [SEL_W-1:0] idx;
    logic [31:0]      data;
  } beat_t;

  logic clk = 1'b0;
  logic rstn;

  sccomp_run_ctrl_if #(.SEL_W(SEL_W)) bus();

  sccomp_run_ctrl #(
    .NREGS    (NREGS),
    .SEL_W    (SEL_W),
    .IDLE_SEL (IDLE_SEL)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          ce_edges = 0;
  int          bp_hits = 0;
  int          exp_instr = 0;
  logic [31:0] exp_retired = '0;
  beat_t       exp_q[$];
  logic [31:0] rf[NREGS];
  logic [31:0] pc;
  logic        mon_stall = 1'b0;
  beat_t       mon_held;
  beat_t       mon_exp;

  // Register file with x0 hard-wired to zero, and a PC that advances on each retired instruction.
  assign bus.reg_data = (bus.reg_sel == '0) ? 32'd0 : rf[bus.reg_sel];
  assign bus.pc_in    = pc;
  always @(posedge clk or posedge rstn) begin
    if (rstn)            pc <= 32'd0;
    else if (bus.cpu_ce) pc <= pc + 32'd4;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sampled mid-cycle so the values seen are those the next rising edge uses.
  always begin
    @(negedge clk);
    #2;
    if (bus.cpu_ce) ce_edges++;
`ifdef SCCOMP_RUN_CTRL_BREAKPOINT_EN
    if (bus.bp_hit) bp_hits++;
`endif
    if (rstn) begin
      mon_stall = 1'b0;
    end else begin
      if (mon_stall && bus.scan_valid) begin
        check("scan_hold_idx", 32'(bus.scan_idx), 32'(mon_held.idx));
        check("scan_hold_data", bus.scan_data, mon_held.data);
      end
      if (bus.scan_valid && bus.scan_ready) begin
        check("scan_beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("scan_beat_idx", 32'(bus.scan_idx), 32'(mon_exp.idx));
          check("scan_beat_data", bus.scan_data, mon_exp.data);
        end
      end
      mon_stall = bus.scan_valid && !bus.scan_ready;
      mon_held  = '{idx: bus.scan_idx, data: bus.scan_data};
    end
  end

  task automatic clear_cmds();
    bus.cmd_halt = 1'b0;
    bus.cmd_step = 1'b0;
    bus.cmd_run  = 1'b0;
    bus.cmd_scan = 1'b0;
  endtask

  // One-cycle command pulse; returns at the negedge where the resulting state is visible.
  task automatic pulse(input logic h, input logic s, input logic r, input logic c);
    @(negedge clk);
    bus.cmd_halt = h;
    bus.cmd_step = s;
    bus.cmd_run  = r;
    bus.cmd_scan = c;
    @(negedge clk);
    clear_cmds();
  endtask

  task automatic check_halted(input string tag);
    check({tag, "_state"}, 32'(bus.state), 32'd0);
    check({tag, "_ce"}, 32'(bus.cpu_ce), 32'd0);
    check({tag, "_retired"}, bus.retired, exp_retired);
  endtask

  // Single step: exactly one instruction, with an optional halt during the step that must do nothing.
  task automatic step_body(input logic halt_noise);
    check("step_state", 32'(bus.state), 32'd2);
    check("step_ce", 32'(bus.cpu_ce), 32'd1);
    bus.cmd_halt = halt_noise;
    @(negedge clk);
    bus.cmd_halt = 1'b0;
    exp_retired += 32'd1;
    exp_instr   += 1;
    check_halted("step_done");
  endtask

  // Free-run for k cycles with ignored commands sprinkled in, then halt: k+1 instructions retire.
  task automatic run_body(input int k);
    check("run_state", 32'(bus.state), 32'd1);
    check("run_ce", 32'(bus.cpu_ce), 32'd1);
    for (int j = 0; j < k; j++) begin
      bus.cmd_step = ($urandom_range(0, 3) == 0);
      bus.cmd_run  = ($urandom_range(0, 3) == 0);
      bus.cmd_scan = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      clear_cmds();
    end
    bus.cmd_halt = 1'b1;
    @(negedge clk);
    bus.cmd_halt = 1'b0;
    exp_retired += 32'(k + 1);
    exp_instr   += k + 1;
    check_halted("run_done");
  endtask

  // Fill the register file and queue the full dump the scan should produce.
  task automatic scan_prepare(input logic put_beef);
    rf[0] = 32'd0;
    for (int i = 1; i < NREGS; i++) rf[i] = $urandom;
    if (put_beef) rf[5] = 32'hDEAD_BEEF;
    for (int i = 0; i < NREGS; i++) exp_q.push_back('{idx: SEL_W'(i), data: rf[i]});
  endtask

  // mode 0: ready tied high; 1: random ready; 2: ready low 4 cycles while idx 2 is presented.
  // abort_idx < 0 runs to completion; otherwise halt when that index is shown with valid == abort_on_valid.
  task automatic scan_body(input int mode, input int abort_idx, input logic abort_on_valid);
    int  cyc = 0;
    int  stall_cnt = 0;
    logic done = 1'b0;
    check("scan_state", 32'(bus.state), 32'd3);
    check("scan_first_valid", 32'(bus.scan_valid), 32'd0);
    while (!done) begin
      check("scan_reg_sel", 32'(bus.reg_sel), 32'(bus.scan_idx));
      if (abort_idx >= 0 && int'(bus.scan_idx) == abort_idx && bus.scan_valid == abort_on_valid) begin
        bus.scan_ready = 1'b0;
        bus.cmd_halt   = 1'b1;
        @(negedge clk);
        bus.cmd_halt = 1'b0;
        check("abort_valid", 32'(bus.scan_valid), 32'd0);
        check("abort_state", 32'(bus.state), 32'd0);
        check("abort_idx", 32'(bus.scan_idx), 32'd0);
        check("abort_reg_sel", 32'(bus.reg_sel), 32'(IDLE_SEL));
        exp_q.delete();
        done = 1'b1;
      end else begin
        case (mode)
          0: bus.scan_ready = 1'b1;
          1: bus.scan_ready = ($urandom_range(0, 1) == 1);
          default: begin
            if (bus.scan_valid && bus.scan_idx == 2 && stall_cnt < 4) begin
              bus.scan_ready = 1'b0;
              stall_cnt++;
            end else begin
              bus.scan_ready = 1'b1;
            end
          end
        endcase
        @(negedge clk);
        cyc++;
        if (bus.state == 2'b00) begin
          done = 1'b1;
          check("scan_done_q_empty", 32'(exp_q.size()), 32'd0);
          check("scan_done_reg_sel", 32'(bus.reg_sel), 32'(IDLE_SEL));
          check("scan_done_idx", 32'(bus.scan_idx), 32'd0);
          check("scan_done_valid", 32'(bus.scan_valid), 32'd0);
        end else if (cyc > 1000) begin
          check("scan_timeout_state", 32'(bus.state), 32'd0);
          exp_q.delete();
          done = 1'b1;
        end
      end
    end
    bus.scan_ready = 1'b0;
    check("scan_retired", bus.retired, exp_retired);
  endtask

  // Random command mix in HALT, resolved by priority halt > step > run > scan.
  task automatic combo_op();
    logic [3:0] m;
    m = 4'($urandom_range(1, 15));
    if (!m[3] && !m[2] && !m[1] && m[0]) scan_prepare(1'b0);
    pulse(m[3], m[2], m[1], m[0]);
    if (m[3])      check_halted("combo_halt");
    else if (m[2]) step_body(1'b0);
    else if (m[1]) run_body($urandom_range(0, 8));
    else           scan_body(1, -1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_cmds();
    bus.scan_ready = 1'b0;
`ifdef SCCOMP_RUN_CTRL_BREAKPOINT_EN
    bus.bp_en   = 1'b0;
    bus.bp_addr = 32'd0;
`endif
    for (int i = 0; i < NREGS; i++) rf[i] = 32'd0;
    rstn = 1'b0;
    #1 rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_ce", 32'(bus.cpu_ce), 32'd0);
    check("rst_reg_sel", 32'(bus.reg_sel), 32'(IDLE_SEL));
    check("rst_valid", 32'(bus.scan_valid), 32'd0);
    check("rst_idx", 32'(bus.scan_idx), 32'd0);
    check("rst_data", bus.scan_data, 32'd0);
    check("rst_retired", bus.retired, 32'd0);
    rstn = 1'b0;

    // Step at cycle 3 after reset, then run with halt after 10 RUN cycles (11 retire).
    @(negedge clk);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    step_body(1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    run_body(10);
    check("run11_total", bus.retired, 32'd12);

    // Full dump with ready tied high, x5 preloaded.
    scan_prepare(1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    scan_body(0, -1, 1'b0);

    // Stall on idx 2 for 4 cycles, then abort while idx 3 is presented.
    scan_prepare(1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    scan_body(2, 3, 1'b1);

    // Same-cycle halt+run in HALT stays in HALT.
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    check_halted("halt_run_combo");

    // Counter wrap: preload all-ones, one RUN cycle (the halt cycle) wraps to 0.
    @(negedge clk);
    force dut.r_retired = 32'hFFFF_FFFF;
    #1 release dut.r_retired;
    exp_retired = 32'hFFFF_FFFF;
    check("wrap_preload", bus.retired, 32'hFFFF_FFFF);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    run_body(0);
    check("wrap_zero", bus.retired, 32'd0);

    // Random operation mix.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: begin
          pulse(1'b0, 1'b1, 1'b0, 1'b0);
          step_body($urandom_range(0, 1) == 1);
        end
        1: begin
          pulse(1'b0, 1'b0, 1'b1, 1'b0);
          run_body($urandom_range(0, 20));
        end
        2: begin
          scan_prepare(1'b0);
          pulse(1'b0, 1'b0, 1'b0, 1'b1);
          scan_body(1, -1, 1'b0);
        end
        3: begin
          scan_prepare(1'b0);
          pulse(1'b0, 1'b0, 1'b0, 1'b1);
          scan_body($urandom_range(0, 2), $urandom_range(0, NREGS - 1), $urandom_range(0, 1) == 1);
        end
        4: combo_op();
        default: begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          check_halted("idle");
        end
      endcase
    end

    // Reset asserted mid-scan while a beat is held.
    scan_prepare(1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 10 && !bus.scan_valid; w++) @(negedge clk);
    check("midrst_beat_up", 32'(bus.scan_valid), 32'd1);
    #3 rstn = 1'b1;
    #1;
    check("midrst_state", 32'(bus.state), 32'd0);
    check("midrst_valid", 32'(bus.scan_valid), 32'd0);
    check("midrst_idx", 32'(bus.scan_idx), 32'd0);
    check("midrst_data", bus.scan_data, 32'd0);
    check("midrst_reg_sel", 32'(bus.reg_sel), 32'(IDLE_SEL));
    check("midrst_retired", bus.retired, 32'd0);
    exp_retired = 32'd0;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);

`ifdef SCCOMP_RUN_CTRL_BREAKPOINT_EN
    // Breakpoint at 0x0C from PC 0: three instructions retire, then resume past it.
    bp_hits     = 0;
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h0000_000C;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    for (int w = 0; w < 50 && bus.state != 2'b00; w++) @(negedge clk);
    exp_retired += 32'd3;
    exp_instr   += 3;
    check_halted("bp_stop");
    check("bp_pc", pc, 32'h0000_000C);
    check("bp_hits", 32'(bp_hits), 32'd1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    run_body(3);
    check("bp_resume_pc", pc, 32'h0000_001C);
    check("bp_hits_after", 32'(bp_hits), 32'd1);
    bus.bp_en = 1'b0;
`endif

    @(negedge clk);
    check("ce_edges", 32'(ce_edges), 32'(exp_instr));
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
